// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor, DIGIT bits per clock, LSB chunk first.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready accept x, y, cin, sub;
//        out_valid/out_ready deliver s, cout (1 = no borrow when subtracting), ovf;
//        busy is high whenever the unit is not idle.
module seq_addsub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_part;
   logic             r_c;
   logic [CW-1:0]    r_k;
   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_ovf;

   logic [IW-1:0]    w_idx;
   logic [DIGIT-1:0] w_ca;
   logic [DIGIT-1:0] w_cb;
   logic [DIGIT:0]   w_sum;
   logic [WIDTH-1:0] w_full;
   logic             w_accept;
   logic             w_last;

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_last   = (r_k == LAST);

   // Current chunk slice and the partial result with this chunk merged in,
   // so the last chunk can commit the full-width result in the same edge.
   always_comb begin
      w_idx  = IW'(int'(r_k) * DIGIT);
      w_ca   = r_a[w_idx +: DIGIT];
      w_cb   = r_b[w_idx +: DIGIT];
      w_sum  = {1'b0, w_ca} + {1'b0, w_cb} + {{DIGIT{1'b0}}, r_c};
      w_full = r_part;
      w_full[w_idx +: DIGIT] = w_sum[DIGIT-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               w_next = RUN;
            end
         end
         RUN: begin
            if (w_last) begin
               w_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_part <= '0;
         r_c    <= 1'b0;
         r_k    <= '0;
         r_s    <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_accept) begin
         // Subtract as x + ~y + 1; cin is not used in that mode.
         r_a    <= x;
         r_b    <= sub ? ~y : y;
         r_c    <= sub ? 1'b1 : cin;
         r_k    <= '0;
         r_part <= '0;
      end else if (r_state == RUN) begin
         r_part <= w_full;
         r_c    <= w_sum[DIGIT];
         r_k    <= r_k + 1'b1;
         if (w_last) begin
            r_s    <= w_full;
            r_cout <= w_sum[DIGIT];
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_full[WIDTH-1] != r_a[WIDTH-1]);
         end
      end
   end

   assign s    = r_s;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: directed and random bench for seq_addsub at 16/4, 8/8 and 8/1.
// Expected results come from a full-width reference model via a scoreboard queue.
module tb_seq_addsub;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        o;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  iv;
   logic [15:0] x;
   logic [15:0] y;
   logic        cin;
   logic        sub;
   logic        ordy;

   logic        ir0, ov0, co0, of0, bz0;
   logic [15:0] s0;
   logic        ir1, ov1, co1, of1, bz1;
   logic [7:0]  s1;
   logic        ir2, ov2, co2, of2, bz2;
   logic [7:0]  s2;

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   seq_addsub #(.WIDTH(16), .DIGIT(4)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
      .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(ov0),
      .out_ready(ordy), .s(s0), .cout(co0), .ovf(of0), .busy(bz0)
   );

   seq_addsub #(.WIDTH(8), .DIGIT(8)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
      .x(x[7:0]), .y(y[7:0]), .cin(cin), .sub(sub), .out_valid(ov1),
      .out_ready(ordy), .s(s1), .cout(co1), .ovf(of1), .busy(bz1)
   );

   seq_addsub #(.WIDTH(8), .DIGIT(1)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
      .x(x[7:0]), .y(y[7:0]), .cin(cin), .sub(sub), .out_valid(ov2),
      .out_ready(ordy), .s(s2), .cout(co2), .ovf(of2), .busy(bz2)
   );

   function automatic exp_t model(input int w, input logic [15:0] xa,
                                  input logic [15:0] ya, input logic ci,
                                  input logic sb);
      exp_t        e;
      logic [16:0] m;
      logic [16:0] t;
      logic [15:0] yb;
      logic        c;
      m   = (17'd1 << w) - 17'd1;
      yb  = sb ? ~ya : ya;
      c   = sb ? 1'b1 : ci;
      t   = ({1'b0, xa} & m) + ({1'b0, yb} & m) + {16'd0, c};
      e.s = t[15:0] & m[15:0];
      e.c = t[w];
      e.o = (xa[w-1] == yb[w-1]) && (e.s[w-1] != xa[w-1]);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic smp(input int sel, output logic [15:0] so,
                      output logic co, output logic of,
                      output logic vo, output logic ir, output logic bz);
      case (sel)
         0: begin
            so = s0; co = co0; of = of0; vo = ov0; ir = ir0; bz = bz0;
         end
         1: begin
            so = {8'd0, s1}; co = co1; of = of1; vo = ov1; ir = ir1; bz = bz1;
         end
         default: begin
            so = {8'd0, s2}; co = co2; of = of2; vo = ov2; ir = ir2; bz = bz2;
         end
      endcase
   endtask

   task automatic run_op(input int sel, input int w, input int n,
                         input logic [15:0] xa, input logic [15:0] ya,
                         input logic ci, input logic sb, input bit hold);
      logic [15:0] so;
      logic        co, of, vo, ir, bz;
      int          lat;
      exp_t        e;
      iv  = 3'b000;
      x   = xa;
      y   = ya;
      cin = ci;
      sub = sb;
      iv[sel] = 1'b1;
      sb_q.push_back(model(w, xa, ya, ci, sb));
      @(posedge clk);
      #1;
      iv  = 3'b000;
      x   = 16'($urandom);
      y   = 16'($urandom);
      cin = ~cin;
      sub = ~sub;
      smp(sel, so, co, of, vo, ir, bz);
      chk("busy_after_accept", bz, 1);
      chk("in_ready_after_accept", ir, 0);
      lat = 0;
      while (!vo && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
         smp(sel, so, co, of, vo, ir, bz);
      end
      chk("latency", lat, n);
      chk("busy_done", bz, 1);
      e = sb_q.pop_front();
      chk("s", so, e.s);
      chk("cout", co, e.c);
      chk("ovf", of, e.o);
      if (hold) begin
         for (int i = 0; i < 5; i++) begin
            iv[sel] = ~iv[sel];
            x = 16'($urandom);
            @(posedge clk);
            #1;
            smp(sel, so, co, of, vo, ir, bz);
            chk("hold_s", so, e.s);
            chk("hold_cout", co, e.c);
            chk("hold_ovf", of, e.o);
            chk("hold_valid", vo, 1);
            chk("hold_in_ready", ir, 0);
         end
         iv = 3'b000;
      end
      ordy = 1'b1;
      @(posedge clk);
      #1;
      ordy = 1'b0;
      smp(sel, so, co, of, vo, ir, bz);
      chk("in_ready_after_hs", ir, 1);
      chk("valid_after_hs", vo, 0);
      chk("busy_after_hs", bz, 0);
      chk("s_kept_idle", so, e.s);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] so;
      logic        co, of, vo, ir, bz;
      iv   = 3'b000;
      x    = '0;
      y    = '0;
      cin  = 1'b0;
      sub  = 1'b0;
      ordy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      smp(0, so, co, of, vo, ir, bz);
      chk("rst_in_ready", ir, 1);
      chk("rst_valid", vo, 0);
      chk("rst_busy", bz, 0);
      chk("rst_s", so, 0);
      chk("rst_cout", co, 0);
      chk("rst_ovf", of, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(0, 16, 4, 16'h1234, 16'h0FED, 1'b1, 1'b0, 1'b0);
      run_op(0, 16, 4, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
      run_op(0, 16, 4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      run_op(0, 16, 4, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
      run_op(0, 16, 4, 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0);
      run_op(0, 16, 4, 16'hA5C3, 16'h1E2F, 1'b0, 1'b0, 1'b1);

      iv  = 3'b001;
      x   = 16'h4321;
      y   = 16'h1111;
      cin = 1'b0;
      sub = 1'b0;
      @(posedge clk);
      #1;
      iv = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      smp(0, so, co, of, vo, ir, bz);
      chk("midrst_s", so, 0);
      chk("midrst_cout", co, 0);
      chk("midrst_ovf", of, 0);
      chk("midrst_valid", vo, 0);
      chk("midrst_busy", bz, 0);
      chk("midrst_in_ready", ir, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op(0, 16, 4, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);

      run_op(1, 8, 1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
      run_op(2, 8, 8, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
      run_op(1, 8, 1, 16'h0080, 16'h0001, 1'b1, 1'b1, 1'b0);
      run_op(2, 8, 8, 16'h0080, 16'h0001, 1'b1, 1'b1, 1'b0);

      for (int i = 0; i < 8; i++) begin
         run_op(0, 16, 4, 16'($urandom), 16'($urandom),
                1'($urandom), 1'($urandom), 1'b0);
         run_op(1, 8, 1, 16'($urandom), 16'($urandom),
                1'($urandom), 1'($urandom), 1'b0);
         run_op(2, 8, 8, 16'($urandom), 16'($urandom),
                1'($urandom), 1'($urandom), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
